aes128_inv_cipher_iter: RTL and testbench
=========================================

Name: aes128_inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher). Performs one round per clock.
- It is the decrypt counterpart of the existing encryption datapath. It consumes the same 1408-bit expanded key schedule produced by the key-expansion block.
- Accepts one 128-bit ciphertext per transaction over a valid/ready handshake. Returns the plaintext over a second valid/ready handshake.
- Sits between the key-expansion block and the system datapath.

Parameters:
- NR, 10, round count. Only 10 (AES-128) is legal. Any other value is an elaboration error.
- STATE_W, 128, state/block width. Fixed; present for readability.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext and key schedule are valid.
- in_ready  output  1  block can accept a new ciphertext.
- ct  input  128  ciphertext. Bits [127:120] are byte 0 (row 0, col 0); bytes are column-major.
- key_words  input  1408  expanded key schedule. [1407:1280] is round key 0; [127:0] is round key 10. Same layout as the key-expansion output.
- out_valid  output  1  pt holds a completed plaintext.
- out_ready  input  1  consumer accepts pt.
- pt  output  128  plaintext, same byte order as ct.

Behaviour:
- Reset (asynchronous assert, released synchronously to clk):
  - FSM goes to IDLE, round counter to 0, state register to 0.
  - in_ready=0 while rst=1, then 1 in IDLE.
  - out_valid=0, pt=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, state <= ct ^ rk10, rnd <= 9, go to BUSY.
  - BUSY: in_ready=0. Each edge with rnd>=1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]), then rnd <= rnd-1.
  - BUSY, final round: when rnd==0, state <= InvSubBytes(InvShiftRows(state)) ^ rk0 (no InvMixColumns), out_valid <= 1, go to DONE.
  - DONE: pt = state, out_valid=1, in_ready=0. On out_ready, out_valid <= 0 and go to IDLE.
- Latency: the accept edge is E0; out_valid rises at E10, i.e. 10 cycles after accept. Throughput is one block per 12 cycles minimum (accept, 9 full rounds, final round, output handshake), with IDLE re-entered after the output handshake.
- No bubbles skipped: in_ready is never asserted in the same cycle as out_valid.
- Key usage:
  - key_words must be held stable from the accept edge until the out_valid handshake.
  - A change while BUSY gives undefined pt; this is not a checked error.
- Back-pressure: pt and out_valid hold indefinitely while out_ready=0.
- out_ready while not DONE is ignored. in_valid while not IDLE is ignored; the ciphertext is not queued.
- Reset mid-operation aborts the block immediately. No partial result is emitted, and the next accept starts clean.
- InvMixColumns coefficients: {0e,0b,0d,09} over GF(2^8), polynomial 0x11b.
- InvShiftRows rotates row r right by r.

Optional Feature:
- Macro: AES_INV_KEY_LATCH_EN.
- With the macro defined:
  - The 1408-bit key_words is captured into an internal register on the accept edge, and all rounds use the latched copy.
  - key_words may change freely after accept.
  - The latched copy is reset to 0.
- Without the macro: no key register, and the stability rule above applies.

Decomposition:
- Package aes_inv_pkg holds:
  - localparams NR=10, STATE_W=128, KEY_W=1408.
  - FSM state enum {IDLE, BUSY, DONE}.
  - GF functions xtime, mul09, mul0b, mul0d, mul0e.
  - A round-key slice function rk(words, r) returning words[1407-r*128 -: 128].
- One natural sub-module: inv_sbox (8-bit in, 8-bit out, combinational inverse S-box case table), instantiated 16 times.
- InvShiftRows and InvMixColumns stay inline as pure wiring/functions.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> pt stable and in_ready=0 throughout; on out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two C.1/App. B ciphertexts and out_ready=1 -> both correct plaintexts, second accept exactly 1 cycle after the first output handshake.
- Reset mid-operation: assert rst at round 5 -> out_valid=0 and pt=0 immediately. Then the C.1 vector decrypts correctly.
- With AES_INV_KEY_LATCH_EN: change key_words to all-ones the cycle after accept -> C.1 pt still correct. Without the macro, that check is skipped.

Source files
------------

// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 inverse cipher.
// Optional feature macro used by the top: AES_INV_KEY_LATCH_EN.
package aes_inv_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned KEY_W   = 1408;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Round key r; round key 0 sits in the top 128 bits of the schedule.
    function automatic logic [127:0] rk(input logic [KEY_W-1:0] words, input logic [3:0] r);
        logic [KEY_W-1:0] sh;
        sh = words << (int'(r) * 128);
        return sh[KEY_W-1 -: 128];
    endfunction

    // Row r rotates right by r: byte (r, c) takes the old byte (r, c - r).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
            o[119 - 32 * c -: 8] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
            o[111 - 32 * c -: 8] = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
            o[103 - 32 * c -: 8] = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: the high nibble picks a 16-byte table row,
// the low nibble picks the byte within it.
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [127:0] w_row;

    // Row lookup on the high nibble.
    always_comb begin
        w_row = '0;
        unique case (i_byte[7:4])
            4'h0: w_row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: w_row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: w_row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: w_row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: w_row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: w_row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: w_row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: w_row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: w_row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: w_row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: w_row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: w_row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: w_row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: w_row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: w_row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: w_row = 128'h172b047eba77d626e169146355210c7d;
            default: w_row = '0;
        endcase
    end

    assign o_byte = w_row[8 * (15 - int'(i_byte[3:0])) +: 8];

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Optional macro AES_INV_KEY_LATCH_EN: latch the key schedule on accept so
// key_words may change while the block is busy.
module aes128_inv_cipher_iter
    import aes_inv_pkg::*;
#(
    parameter int unsigned NR      = 10,
    parameter int unsigned STATE_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] ct,
    input  logic [KEY_W-1:0]   key_words,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] pt
);

    if (NR != 10 || STATE_W != 128) begin : g_bad_cfg
        $error("aes128_inv_cipher_iter: only NR=10 and STATE_W=128 are supported");
    end

    fsm_e         r_fsm;
    logic [3:0]   r_rnd;
    logic [127:0] r_state;
    logic         r_out_valid;

    logic [KEY_W-1:0] w_key;
    logic [127:0]     w_isr;
    logic [127:0]     w_isb;
    logic [127:0]     w_ark;
    logic [127:0]     w_imc;
    logic [127:0]     w_init;

`ifdef AES_INV_KEY_LATCH_EN
    logic [KEY_W-1:0] r_key;

    // Capture the schedule on the accept edge; rounds read only this copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key <= '0;
        end else if (r_fsm == IDLE && in_valid) begin
            r_key <= key_words;
        end
    end

    assign w_key = r_key;
`else
    assign w_key = key_words;
`endif

    // Initial AddRoundKey always uses the live schedule: it happens on the accept edge.
    assign w_init = ct ^ rk(key_words, 4'(NR));

    assign w_isr = inv_shift_rows(r_state);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .i_byte (w_isr[8*g +: 8]),
            .o_byte (w_isb[8*g +: 8])
        );
    end

    assign w_ark = w_isb ^ rk(w_key, r_rnd);
    assign w_imc = inv_mix_columns(w_ark);

    // Control FSM and round datapath; out_valid is registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_rnd       <= 4'd0;
            r_state     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= w_init;
                        r_rnd   <= 4'(NR - 1);
                        r_fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_rnd != 4'd0) begin
                        r_state <= w_imc;
                        r_rnd   <= r_rnd - 4'd1;
                    end else begin
                        // Final round skips InvMixColumns.
                        r_state     <= w_ark;
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    // Gated by rst so in_ready is low for the whole reset pulse.
    assign in_ready  = (r_fsm == IDLE) & ~rst;
    assign out_valid = r_out_valid;
    assign pt        = r_out_valid ? r_state : '0;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Self-checking bench for aes128_inv_cipher_iter. The reference is a forward
// AES-128 cipher built from GF(2^8) arithmetic: random plaintexts are encrypted
// here and the DUT must return them. Honours AES_INV_KEY_LATCH_EN.
module tb_aes128_inv_cipher_iter;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [127:0]    ct = '0;
    logic [1407:0]   key_words = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [127:0]    pt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_t [256];
    logic [1407:0] kw_c1, kw_b;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes128_inv_cipher_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key_words (key_words),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox_t[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] kw;
        rcon = 8'h01;
        kw = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) kw[1407 - 32 * i -: 32] = w[i];
        return kw;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [1407:0] kw);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8 * i -: 8] ^ kw[1407 - 8 * i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ kw[1407 - 128 * rnd - 8 * i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Starts at a sample point with the DUT idle; returns the captured pt and the
    // number of edges from accept to out_valid (40 means it never came).
    task automatic run_block(input logic [127:0] c, input logic [1407:0] kw, input int hold,
                             output logic [127:0] got, output int lat);
        ct = c; key_words = kw; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = pt;
        repeat (hold) @(posedge clk);
        if (hold > 0) #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; ct = C1_CT; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (pt !== 128'h0) begin n_fail++; $display("FAIL reset_pt: got %h want 0", pt); end
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_fips_c1();
        logic [127:0] got; int lat;
        run_block(C1_CT, kw_c1, 0, got, lat);
        n_checks++;
        if (got !== C1_PT) begin n_fail++; $display("FAIL c1_pt: got %h want %h", got, C1_PT); end
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL c1_latency: got %0d want 10", lat); end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL c1_idle_after: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_fips_b();
        logic [127:0] got; int lat;
        run_block(B_CT, kw_b, 2, got, lat);
        n_checks++;
        if (got !== B_PT) begin n_fail++; $display("FAIL b_pt: got %h want %h", got, B_PT); end
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL b_latency: got %0d want 10", lat); end
    endtask

    task automatic test_random();
        logic [127:0] k, p, c, got; logic [1407:0] kw; int lat;
        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            kw = expand(k);
            c = encrypt(p, kw);
            run_block(c, kw, int'($urandom_range(0, 3)), got, lat);
            n_checks++;
            if (got !== p) begin n_fail++; $display("FAIL rand_pt[%0d]: got %h want %h", n, got, p); end
            n_checks++;
            if (lat !== 10) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 10", n, lat); end
        end
    endtask

    task automatic test_backpressure();
        int lat; bit bad;
        ct = B_CT; key_words = kw_b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;  // ignored while busy
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL bp_latency: got %0d want 10", lat); end
        in_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (pt !== B_PT || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++; bad = 1'b1;
                $display("FAIL bp_hold[%0d]: pt %h in_ready %b out_valid %b want %h 0 1",
                         i, pt, in_ready, out_valid, B_PT);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int e, n_acc, n_hs;
        int acc [2];
        int hs [2];
        logic [127:0] got [2];
        bit overlap;
        acc = '{0, 0}; hs = '{0, 0}; got = '{128'h0, 128'h0};
        n_acc = 0; n_hs = 0; e = 0; overlap = 1'b0;
        out_ready = 1'b1; ct = C1_CT; key_words = kw_c1; in_valid = 1'b1;
        while (n_hs < 2 && e < 80) begin
            if (n_acc == 2) in_valid = 1'b0;
            if (n_hs == 1 && n_acc == 1) begin ct = B_CT; key_words = kw_b; end
            if (in_ready && out_valid) overlap = 1'b1;
            if (out_valid && out_ready) begin got[n_hs] = pt; hs[n_hs] = e + 1; n_hs++; end
            if (in_valid && in_ready && n_acc < 2) begin acc[n_acc] = e + 1; n_acc++; end
            @(posedge clk); #1;
            e++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (n_hs !== 2) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 2", n_hs); end
        n_checks++;
        if (got[0] !== C1_PT) begin n_fail++; $display("FAIL b2b_pt0: got %h want %h", got[0], C1_PT); end
        n_checks++;
        if (got[1] !== B_PT) begin n_fail++; $display("FAIL b2b_pt1: got %h want %h", got[1], B_PT); end
        n_checks++;
        if (acc[1] - hs[0] !== 1) begin
            n_fail++; $display("FAIL b2b_gap: got %0d want 1", acc[1] - hs[0]);
        end
        n_checks++;
        if (hs[0] - acc[0] !== 11) begin
            n_fail++; $display("FAIL b2b_period: got %0d want 11", hs[0] - acc[0]);
        end
        n_checks++;
        if (overlap !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap: got 1 want 0"); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got; int lat; bit seen;
        ct = C1_CT; key_words = kw_c1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || pt !== 128'h0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: out_valid %b pt %h in_ready %b want 0 0 0",
                               out_valid, pt, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output: got 1 want 0"); end
        run_block(C1_CT, kw_c1, 0, got, lat);
        n_checks++;
        if (got !== C1_PT) begin n_fail++; $display("FAIL midrst_c1_pt: got %h want %h", got, C1_PT); end
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL midrst_latency: got %0d want 10", lat); end
    endtask

    task automatic test_key_latch();
`ifdef AES_INV_KEY_LATCH_EN
        int lat;
        ct = C1_CT; key_words = kw_c1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        key_words = '1;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (pt !== C1_PT) begin n_fail++; $display("FAIL latch_pt: got %h want %h", pt, C1_PT); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        key_words = kw_c1;
`endif
    endtask

    initial begin
        build_sbox();
        kw_c1 = expand(C1_KEY);
        kw_b  = expand(B_KEY);
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_key_latch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
